// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nsa_pkg: shared state encoding and slice width for the nibble-serial adder.
// Contents:
//   state_e   - sequencer states IDLE/RUN/DONE
//   NIBBLE_W  - width of the single adder slice
package nsa_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand/result handshake bundle for the nibble-serial adder.
// Signals:
//   in_valid/in_ready   - operand handshake (source -> adder)
//   a, b, cin           - operands and carry-in
//   sub                 - subtract request, present only with NIBBLE_ADD_SUB_EN
//   out_valid/out_ready - result handshake (adder -> consumer)
//   sum, cout           - result and carry-out
// Modports: master = source/consumer side, slave = adder side.
interface nibble_serial_add_ctrl_if
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef NIBBLE_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_ADD_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_add_ctrl_add4_slice.sv
// add4_slice: combinational 4-bit ripple adder built from gate-level full adders.
// Ports:
//   a, b - nibble operands
//   ci   - carry in
//   s    - nibble sum
//   c4   - carry out of bit 3
module add4_slice
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                c4
);
  logic [NIBBLE_W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c4 = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: wide adder that reuses one 4-bit slice, one nibble per clock, LSB first.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - operand/result handshake (slave modport of nibble_serial_add_ctrl_if)
//   busy - high while an operation is running or its result is waiting
// Optional: define NIBBLE_ADD_SUB_EN to add a sub input that turns the op into a - b
// (cout = 1 then means no borrow).
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  bus,
  output logic                     busy
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [NIBBLE_W-1:0] s4;
  logic          c4;
  logic          sub_i;

`ifdef NIBBLE_ADD_SUB_EN
  assign sub_i = bus.sub;
`else
  assign sub_i = 1'b0;
`endif

  add4_slice u_slice (
    .a  (a_sh_q[NIBBLE_W-1:0]),
    .b  (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (s4),
    .c4 (c4)
  );

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        // subtraction is a + ~b + 1, so the carry seed replaces cin
        a_sh_d  = bus.a;
        b_sh_d  = sub_i ? ~bus.b : bus.b;
        carry_d = sub_i ? 1'b1 : bus.cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // each slice result enters at the top so after NIBBLES shifts nibble 0 sits at the bottom
        sum_d   = {s4, sum_q[W-1:NIBBLE_W]};
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        carry_d = c4;
        idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
        state_d = (idx_q == LAST) ? DONE : RUN;
        cout_d  = (idx_q == LAST) ? c4 : cout_q;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench with an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic sub = 1'b0;
  int   checks = 0;
  int   fails = 0;

  nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

`ifdef NIBBLE_ADD_SUB_EN
  assign bus.sub = sub;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing, 2 result held; result is plain W+1-bit arithmetic.
  int           m_st = 0;
  int           m_cnt = 0;
  logic [W:0]   m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_st  <= 0;
      m_cnt <= 0;
    end else if (m_st == 0) begin
      if (bus.in_valid) begin
        m_res <= sub ? ({1'b0, bus.a} + {1'b0, ~bus.b} + (W+1)'(1))
                     : ({1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin));
        m_cnt <= N;
        m_st  <= 1;
      end
    end else if (m_st == 1) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_st <= 2;
    end else if (bus.out_ready) begin
      m_st <= 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(m_st == 0 && !rst));
    chk("out_valid", 64'(bus.out_valid), 64'(m_st == 2));
    chk("busy", 64'(busy), 64'(m_st != 0));
    if (m_st == 2) begin
      chk("model_sum", 64'(bus.sum), 64'(m_res[W-1:0]));
      chk("model_cout", 64'(bus.cout), 64'(m_res[W]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i, input logic s_i);
    int n = 0;
    bus.a = a_i;
    bus.b = b_i;
    bus.cin = c_i;
    sub = s_i;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    chk("accept_wait", 64'(bus.in_ready), 64'(1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int edges);
    edges = 1;
    while (!bus.out_valid && edges < 50) begin
      step();
      edges++;
    end
    chk("result_wait", 64'(bus.out_valid), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic c_i, input logic s_i, input logic [W-1:0] e_sum, input logic e_cout);
    int e;
    start(a_i, b_i, c_i, s_i);
    wait_result(e);
    chk({name, "_latency"}, 64'(e), 64'(N + 1));
    chk({name, "_sum"}, 64'(bus.sum), 64'(e_sum));
    chk({name, "_cout"}, 64'(bus.cout), 64'(e_cout));
    step();
    chk({name, "_valid_1cyc"}, 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    int e;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_cout", 64'(bus.cout), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    run_op("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("mix", 16'h8000, 16'h8001, 1'b1, 1'b0, 16'h0002, 1'b1);

    bus.out_ready = 1'b0;
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result(e);
    bus.a = 16'hAAAA;
    bus.b = 16'h0101;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    repeat (6) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
      chk("bp_sum", 64'(bus.sum), 64'(16'h3333));
      chk("bp_cout", 64'(bus.cout), 64'(0));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_taken", 64'(bus.out_valid), 64'(0));
    chk("bp_ready_after", 64'(bus.in_ready), 64'(1));
    step();
    bus.in_valid = 1'b0;
    chk("bp_new_busy", 64'(busy), 64'(1));
    wait_result(e);
    chk("bp_new_latency", 64'(e), 64'(N + 1));
    chk("bp_new_sum", 64'(bus.sum), 64'(16'hABAB));
    step();

    start(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_sum", 64'(bus.sum), 64'(0));
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    rst = 1'b0;
    repeat (8) begin
      chk("midrst_no_valid", 64'(bus.out_valid), 64'(0));
      step();
    end
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

    bus.a = 16'h5555;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_vs_valid_busy", 64'(busy), 64'(0));
    step();
    chk("rst_vs_valid_idle", 64'(busy), 64'(0));

`ifdef NIBBLE_ADD_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    run_op("sub_off", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
